rx_key_iv_assembler: RTL and testbench
======================================

Name: rx_key_iv_assembler

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (8-bit data plus a one-cycle load strobe).
- Parses framed messages into a 128-bit key and a 128-bit IV for the crypto core, checks each frame with an XOR checksum, and aborts stalled frames on an inter-byte timeout.
- Latched key/IV are held stable until the next good frame of the same type.

Parameters:
- PAYLOAD_BYTES, 16, payload bytes per frame; key/iv width = 8*PAYLOAD_BYTES.
- SYNC_BYTE, 8'hA5, frame start marker.
- TYPE_KEY, 8'h4B ('K'), type code selecting the key register.
- TYPE_IV, 8'h49 ('I'), type code selecting the IV register.
- TIMEOUT_CYCLES, 50000, maximum clk cycles between consecutive accepted bytes inside a frame.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  8  received byte from the UART receiver, valid only when load=1.
- load  input  1  one-cycle strobe; din is sampled on this cycle.
- key  output  128  last good key; first payload byte in bits [127:120].
- iv  output  128  last good IV; same byte ordering as key.
- key_valid  output  1  one-cycle pulse when key is updated.
- iv_valid  output  1  one-cycle pulse when iv is updated.
- frame_err  output  1  one-cycle pulse on frame abort.
- err_code  output  2  cause of the last abort (01 bad type, 10 checksum, 11 timeout); held until the next abort.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE; key, iv, staging register, byte counter, checksum and timer = 0; key_valid=iv_valid=frame_err=0; err_code=00; busy=0. Reset mid-frame discards the partial frame and does not pulse frame_err.
- Frame format: SYNC_BYTE, TYPE, PAYLOAD_BYTES data bytes, CHK. A frame is good when CHK equals the XOR of TYPE and all payload bytes.
- FSM states and transitions (each advances only on a load cycle unless stated):
  - IDLE: load with din==SYNC_BYTE goes to TYPE. Any other byte is ignored silently.
  - TYPE: if din is TYPE_KEY or TYPE_IV, latch the selector, set chk=din, clear the byte counter, and go to PAYLOAD. Any other byte gives frame_err with err_code=01 and a return to IDLE.
  - PAYLOAD: shift din into the staging register MSB-first (staging <= {staging[119:0], din}), chk ^= din, counter++. When the counter reaches PAYLOAD_BYTES-1 on a load, go to CHECK. SYNC_BYTE here is ordinary data.
  - CHECK: if din==chk, copy staging into key or iv (per the selector) and pulse the matching valid in the cycle after the load. If din!=chk, frame_err with err_code=10 and no register change. Either way, return to IDLE.
- Latency: key/iv and their valid pulse appear exactly 1 cycle after the load that carried CHK; frame_err likewise appears 1 cycle after the offending load.
- Timeout:
  - The timer clears on every accepted load while busy and increments every cycle in which busy=1 and load=0.
  - When the timer reaches TIMEOUT_CYCLES-1 with no load, assert frame_err with err_code=11 and go to IDLE.
  - If load and the timeout condition coincide in the same cycle, load wins: the byte is processed and the timer clears.
  - The timer is idle in IDLE.
- Back-to-back frames: the SYNC of the next frame may arrive on the cycle right after the valid pulse and is accepted normally.
- Outputs are registered; no combinational path from din/load to any output.
- Timer width is $clog2(TIMEOUT_CYCLES); byte counter width is $clog2(PAYLOAD_BYTES).

Decomposition:
- Shared package rx_frame_pkg holds:
  - FSM state enum (ST_IDLE, ST_TYPE, ST_PAYLOAD, ST_CHECK).
  - err_code localparams (ERR_NONE=00, ERR_TYPE=01, ERR_CHK=10, ERR_TIMEOUT=11).
  - SYNC/TYPE default constants, shared with the future TX-side framer.
- One sub-module is natural: rx_gap_timer (counter with clear/enable/expire), reused by the TX framer.
- The FSM, staging register and checksum stay in the top module.

Test Plan:
- Good key frame: A5, 4B, bytes 00..0F, CHK=4B -> 1 cycle after the CHK load, key=128'h000102030405060708090A0B0C0D0E0F, key_valid pulses 1 cycle, iv unchanged (0), busy drops.
- Bad checksum: A5, 49, 16×FF, CHK=00 (correct is 49) -> frame_err pulse, err_code=10, iv stays 0, no iv_valid.
- Bad type, then recovery: A5, 33 -> frame_err, err_code=01. A following good IV frame with payload 16×11, CHK=49 -> iv=128'h1111…11, iv_valid pulse.
- Timeout: with TIMEOUT_CYCLES=100, send A5, 4B, 5 payload bytes, then idle -> frame_err with err_code=11 exactly 100 cycles after the last load; key unchanged. Second run with a load landing on the expiry cycle -> no error, byte accepted.
- Reset mid-frame: synchronous reset after 8 payload bytes -> all outputs 0, no frame_err. Then a complete good key frame is accepted normally.
- Noise in IDLE plus back-to-back frames: bytes 00, FF, 4B before A5 are ignored; a key frame immediately followed by an IV frame (SYNC on the cycle after key_valid) -> both valid pulses fire with correct data.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// Shared framing definitions for the UART key/IV receive path and the future TX framer.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TYPE    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } rx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TYPE    = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] TYPE_KEY_DEF  = 8'h4B;
    localparam logic [7:0] TYPE_IV_DEF   = 8'h49;

    localparam int unsigned PAYLOAD_BYTES_DEF  = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 50000;

endpackage

// File: rtl/rx_key_iv_assembler_if.sv
// Byte-stream input and key/IV result bundle between the UART receiver, the assembler and the crypto core.
interface rx_key_iv_assembler_if #(
    parameter int unsigned DATA_W = 128
);
    logic [7:0]        din;
    logic              load;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] iv;
    logic              key_valid;
    logic              iv_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    modport master (
        output din, load,
        input  key, iv, key_valid, iv_valid, frame_err, err_code, busy
    );

    modport slave (
        input  din, load,
        output key, iv, key_valid, iv_valid, frame_err, err_code, busy
    );
endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter: clears on clr_i, counts while en_i, flags the cycle it would reach LIMIT.
module rx_gap_timer #(
    parameter int unsigned LIMIT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c
);
    localparam int unsigned TMR_W = $clog2(LIMIT);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TMR_W'(1);
        end
    end

    assign expire_c = en_i && (cnt_q == TMR_W'(LIMIT - 1));

endmodule

// File: rtl/rx_key_iv_assembler.sv
// Parses SYNC/TYPE/payload/CHK frames from the UART byte stream into latched key and IV registers.
module rx_key_iv_assembler
    import rx_frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = PAYLOAD_BYTES_DEF,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [7:0]  TYPE_KEY       = TYPE_KEY_DEF,
    parameter logic [7:0]  TYPE_IV        = TYPE_IV_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    rx_key_iv_assembler_if.slave   bus
);
    localparam int unsigned DATA_W = 8 * PAYLOAD_BYTES;
    localparam int unsigned CNT_W  = $clog2(PAYLOAD_BYTES);

    rx_state_e         state_q, state_d;
    logic              sel_iv_q, sel_iv_d;
    logic [DATA_W-1:0] staging_q, staging_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        chk_q, chk_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] iv_q, iv_d;
    logic              key_valid_q, key_valid_d;
    logic              iv_valid_q, iv_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              busy_q, busy_d;

    logic tmr_clr, tmr_en, tmr_expire;

    // Gap timer runs only mid-frame; any accepted byte restarts it, so a load on the expiry cycle wins.
    assign tmr_clr = (state_q == ST_IDLE) || bus.load;
    assign tmr_en  = (state_q != ST_IDLE) && !bus.load;

    rx_gap_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_c (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_iv_q    <= 1'b0;
            staging_q   <= '0;
            cnt_q       <= '0;
            chk_q       <= '0;
            key_q       <= '0;
            iv_q        <= '0;
            key_valid_q <= 1'b0;
            iv_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_iv_q    <= sel_iv_d;
            staging_q   <= staging_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            key_q       <= key_d;
            iv_q        <= iv_d;
            key_valid_q <= key_valid_d;
            iv_valid_q  <= iv_valid_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_iv_d    = sel_iv_q;
        staging_d   = staging_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        key_d       = key_q;
        iv_d        = iv_q;
        key_valid_d = 1'b0;
        iv_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.load && (bus.din == SYNC_BYTE)) begin
                    state_d = ST_TYPE;
                end
            end
            ST_TYPE: begin
                if (bus.load) begin
                    if ((bus.din == TYPE_KEY) || (bus.din == TYPE_IV)) begin
                        sel_iv_d = (bus.din == TYPE_IV);
                        chk_d    = bus.din;
                        cnt_d    = '0;
                        state_d  = ST_PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_TYPE;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.load) begin
                    staging_d = {staging_q[DATA_W-9:0], bus.din};
                    chk_d     = chk_q ^ bus.din;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (bus.load) begin
                    if (bus.din == chk_q) begin
                        if (sel_iv_q) begin
                            iv_d       = staging_q;
                            iv_valid_d = 1'b1;
                        end else begin
                            key_d       = staging_q;
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry only fires on a no-load cycle, so it never collides with the byte handling above.
        if (tmr_expire) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.key       = key_q;
    assign bus.iv        = iv_q;
    assign bus.key_valid = key_valid_q;
    assign bus.iv_valid  = iv_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rx_key_iv_assembler.sv
// Directed bench for rx_key_iv_assembler with a shortened 100-cycle inter-byte timeout.
module tb_rx_key_iv_assembler;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rx_key_iv_assembler_if #(.DATA_W(128)) bus ();

    rx_key_iv_assembler #(
        .PAYLOAD_BYTES  (16),
        .SYNC_BYTE      (8'hA5),
        .TYPE_KEY       (8'h4B),
        .TYPE_IV        (8'h49),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Presents one byte for exactly one sampling edge; returns 1ns after that edge.
    task automatic drive_byte(input logic [7:0] b);
        bus.din  = b;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic send_payload(input logic [127:0] p, input int first, input int count);
        logic [127:0] tmp;
        tmp = p;
        for (int i = first; i < first + count; i++) begin
            drive_byte(tmp[127 - 8*i -: 8]);
        end
    endtask

    task automatic send_frame(input logic [7:0] typ, input logic [127:0] p, input logic [7:0] chk);
        drive_byte(8'hA5);
        drive_byte(typ);
        send_payload(p, 0, 16);
        drive_byte(chk);
    endtask

    localparam logic [127:0] P_INC   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] P_FF    = {16{8'hFF}};
    localparam logic [127:0] P_11    = {16{8'h11}};
    localparam logic [127:0] P_5A    = {16{8'h5A}};
    localparam logic [127:0] P_C3    = {16{8'hC3}};
    localparam logic [127:0] P_INC1  = 128'h0102030405060708090A0B0C0D0E0F10;

    initial begin
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.din  = 8'h00;
        bus.load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_key",       bus.key, 128'h0);
        check("reset_iv",        bus.iv, 128'h0);
        check("reset_key_valid", 128'(bus.key_valid), 128'h0);
        check("reset_iv_valid",  128'(bus.iv_valid), 128'h0);
        check("reset_frame_err", 128'(bus.frame_err), 128'h0);
        check("reset_err_code",  128'(bus.err_code), 128'h0);
        check("reset_busy",      128'(bus.busy), 128'h0);

        // Noise in IDLE is ignored
        drive_byte(8'h00);
        drive_byte(8'hFF);
        drive_byte(8'h4B);
        check("noise_busy", 128'(bus.busy), 128'h0);
        check("noise_err",  128'(bus.frame_err), 128'h0);

        // Good key frame
        drive_byte(8'hA5);
        check("sync_busy", 128'(bus.busy), 128'h1);
        drive_byte(8'h4B);
        send_payload(P_INC, 0, 16);
        drive_byte(8'h4B);
        check("key1_value", bus.key, P_INC);
        check("key1_valid", 128'(bus.key_valid), 128'h1);
        check("key1_iv",    bus.iv, 128'h0);
        check("key1_busy",  128'(bus.busy), 128'h0);
        @(posedge clk); #1;
        check("key1_valid_drop", 128'(bus.key_valid), 128'h0);

        // Bad checksum on IV frame
        send_frame(8'h49, P_FF, 8'h00);
        check("badchk_err",      128'(bus.frame_err), 128'h1);
        check("badchk_code",     128'(bus.err_code), 128'h2);
        check("badchk_iv",       bus.iv, 128'h0);
        check("badchk_iv_valid", 128'(bus.iv_valid), 128'h0);
        @(posedge clk); #1;
        check("badchk_err_drop", 128'(bus.frame_err), 128'h0);
        check("badchk_code_hold", 128'(bus.err_code), 128'h2);

        // Bad type then recovery
        drive_byte(8'hA5);
        drive_byte(8'h33);
        check("badtype_err",  128'(bus.frame_err), 128'h1);
        check("badtype_code", 128'(bus.err_code), 128'h1);
        check("badtype_busy", 128'(bus.busy), 128'h0);
        send_frame(8'h49, P_11, 8'h49);
        check("iv1_value", bus.iv, P_11);
        check("iv1_valid", 128'(bus.iv_valid), 128'h1);
        check("iv1_key",   bus.key, P_INC);
        check("iv1_code_hold", 128'(bus.err_code), 128'h1);

        // Back-to-back key then IV frame
        send_frame(8'h4B, P_5A, 8'h4B);
        check("b2b_key",       bus.key, P_5A);
        check("b2b_key_valid", 128'(bus.key_valid), 128'h1);
        @(posedge clk); #1;
        send_frame(8'h49, P_C3, 8'h49);
        check("b2b_iv",       bus.iv, P_C3);
        check("b2b_iv_valid", 128'(bus.iv_valid), 128'h1);
        check("b2b_key_hold", bus.key, P_5A);
        check("b2b_no_keyv",  128'(bus.key_valid), 128'h0);

        // Timeout after 5 payload bytes
        drive_byte(8'hA5);
        drive_byte(8'h4B);
        send_payload(P_INC1, 0, 5);
        check("to_busy", 128'(bus.busy), 128'h1);
        cyc = 0;
        while (bus.frame_err !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("to_latency", 128'(cyc), 128'd100);
        check("to_code",    128'(bus.err_code), 128'h3);
        check("to_busy_low", 128'(bus.busy), 128'h0);
        check("to_key_hold", bus.key, P_5A);

        // Load on the expiry cycle wins
        drive_byte(8'hA5);
        drive_byte(8'h4B);
        send_payload(P_INC1, 0, 5);
        repeat (99) @(posedge clk);
        #1;
        check("race_pre_err", 128'(bus.frame_err), 128'h0);
        drive_byte(8'h06);
        check("race_err",  128'(bus.frame_err), 128'h0);
        check("race_busy", 128'(bus.busy), 128'h1);
        send_payload(P_INC1, 6, 10);
        drive_byte(8'h5B);
        check("race_key",       bus.key, P_INC1);
        check("race_key_valid", 128'(bus.key_valid), 128'h1);
        check("race_code_hold", 128'(bus.err_code), 128'h3);

        // Reset mid-frame
        drive_byte(8'hA5);
        drive_byte(8'h4B);
        send_payload(P_5A, 0, 8);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_key",  bus.key, 128'h0);
        check("mrst_iv",   bus.iv, 128'h0);
        check("mrst_busy", 128'(bus.busy), 128'h0);
        check("mrst_err",  128'(bus.frame_err), 128'h0);
        check("mrst_code", 128'(bus.err_code), 128'h0);
        @(posedge clk); #1;
        check("mrst_err_after", 128'(bus.frame_err), 128'h0);
        send_frame(8'h4B, P_INC, 8'h4B);
        check("mrst_key2",       bus.key, P_INC);
        check("mrst_key2_valid", 128'(bus.key_valid), 128'h1);
        check("mrst_iv2",        bus.iv, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
